transmissor_imagem_oled: RTL



---
 rtl/transmissor_imagem_oled.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/transmissor_imagem_oled.sv
// rtl/transmissor_imagem_oled.sv - serializes a 128x64 monochrome frame to an SSD1306-style OLED over write-only 4-wire SPI
//
// Consumer end of the image controller's frame buffer. An accepted start pulse
// freezes a private copy of the frame, then the frame is shifted out MSB first
// in SPI mode 0 with chip select held low for the whole transfer.
//
// Build option:
//   TRANSMISSOR_ENDERECO_EN - when defined, every frame is preceded by the
//                             6-byte column/page window command (dc=0):
//                             21 00 7F 22 00 07, so the panel always starts
//                             writing at column 0, page 0. When undefined the
//                             frame is data bytes only and dc stays 1.
//
// Parameters:
//   DIV_CLK    clk cycles per SCLK half-period (1..255)
//   N_BYTES    frame length in bytes
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   imagem      frame, byte i = imagem[i*8 +: 8]
//   iniciar     one-cycle start pulse
//   spi_sclk    SPI clock, idle low, data sampled on rising edge
//   spi_mosi    serial data, MSB first
//   spi_cs_n    chip select, active low
//   spi_dc      0 = command byte, 1 = data byte
//   ocupado     high from the cycle after an accepted start until frame end
//   quadro_fim  one-cycle pulse when the frame completes

module transmissor_imagem_oled #(
    parameter int DIV_CLK = 2,
    parameter int N_BYTES = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_BYTES*8-1:0]   imagem,
    input  logic                   iniciar,
    output logic                   spi_sclk,
    output logic                   spi_mosi,
    output logic                   spi_cs_n,
    output logic                   spi_dc,
    output logic                   ocupado,
    output logic                   quadro_fim
);

    localparam int         AW       = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [7:0]  DIV_ULT  = 8'(DIV_CLK - 1);
    localparam logic [10:0] BYTE_ULT = 11'(N_BYTES - 1);

`ifdef TRANSMISSOR_ENDERECO_EN
    localparam logic [10:0] CMD_ULT      = 11'd5;
    localparam logic [7:0]  CMD_PRIMEIRO = 8'h21;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        INICIO  = 3'd1,
        COMANDO = 3'd2,
        DADOS   = 3'd3,
        GUARDA  = 3'd4
    } estado_t;

    // Column window 0..127, page window 0..7.
    function automatic logic [7:0] cmd_byte(input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = 8'h21;
            3'd1:    b = 8'h00;
            3'd2:    b = 8'h7F;
            3'd3:    b = 8'h22;
            3'd4:    b = 8'h00;
            3'd5:    b = 8'h07;
            default: b = 8'h00;
        endcase
        return b;
    endfunction
`else
    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        INICIO  = 3'd1,
        DADOS   = 3'd3,
        GUARDA  = 3'd4
    } estado_t;
`endif

    estado_t                estado_q;
    logic [7:0]             div_q;
    logic [2:0]             bit_q;
    logic [10:0]            byte_q;
    logic [7:0]             byte_atual_q;
    logic [N_BYTES*8-1:0]   snap_q;
    logic                   sclk_q;
    logic                   mosi_q;
    logic                   cs_n_q;
    logic                   dc_q;
    logic                   ocupado_q;
    logic                   fim_q;

    logic                   aceita_d;
    logic                   fim_div_d;
    logic [2:0]             bit_prox_d;
    logic [AW-1:0]          idx_d;
    logic [7:0]             prox_dado_d;
`ifdef TRANSMISSOR_ENDERECO_EN
    logic [7:0]             prox_cmd_d;
`endif

    always_comb begin
        // A start landing on the quadro_fim cycle is dropped: the frame that
        // just ended must be seen as finished before a new one may begin.
        aceita_d   = (estado_q == OCIOSO) && iniciar && !fim_q;
        fim_div_d  = (div_q == DIV_ULT);
        bit_prox_d = bit_q - 3'd1;
        // Only one snapshot read port: it always points at the byte that will
        // be loaded next (byte 0 outside DADOS, byte_q+1 inside).
        idx_d      = '0;
        if (estado_q == DADOS) begin
            idx_d = byte_q[AW-1:0] + AW'(1);
        end
        prox_dado_d = snap_q[{idx_d, 3'b000} +: 8];
`ifdef TRANSMISSOR_ENDERECO_EN
        prox_cmd_d  = cmd_byte(byte_q[2:0] + 3'd1);
`endif
    end

    // Frame copy taken on the accepting edge; the source may change freely
    // while the frame is in flight.
    always_ff @(posedge clk) begin
        if (aceita_d) begin
            snap_q <= imagem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= OCIOSO;
            div_q        <= '0;
            bit_q        <= '0;
            byte_q       <= '0;
            byte_atual_q <= '0;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            dc_q         <= 1'b0;
            ocupado_q    <= 1'b0;
            fim_q        <= 1'b0;
        end else begin
            fim_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (aceita_d) begin
                        estado_q  <= INICIO;
                        cs_n_q    <= 1'b0;
                        ocupado_q <= 1'b1;
                        div_q     <= '0;
                        byte_q    <= '0;
                    end
                end

                // Setup guard between CS falling and the first SCLK phase.
                INICIO: begin
                    if (fim_div_d) begin
                        div_q  <= '0;
                        bit_q  <= 3'd7;
                        byte_q <= '0;
                        sclk_q <= 1'b0;
`ifdef TRANSMISSOR_ENDERECO_EN
                        estado_q     <= COMANDO;
                        byte_atual_q <= CMD_PRIMEIRO;
                        mosi_q       <= CMD_PRIMEIRO[7];
                        dc_q         <= 1'b0;
`else
                        estado_q     <= DADOS;
                        byte_atual_q <= prox_dado_d;
                        mosi_q       <= prox_dado_d[7];
                        dc_q         <= 1'b1;
`endif
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end

`ifdef TRANSMISSOR_ENDERECO_EN
                COMANDO,
`endif
                DADOS: begin
                    // Each bit: DIV_CLK cycles low, DIV_CLK cycles high. mosi
                    // and dc only move when the high phase ends, i.e. on the
                    // first cycle of the next low phase.
                    if (!fim_div_d) begin
                        div_q <= div_q + 8'd1;
                    end else begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q != 3'd0) begin
                                bit_q  <= bit_prox_d;
                                mosi_q <= byte_atual_q[bit_prox_d];
                            end else begin
                                bit_q <= 3'd7;
`ifdef TRANSMISSOR_ENDERECO_EN
                                if (estado_q == COMANDO) begin
                                    if (byte_q == CMD_ULT) begin
                                        estado_q     <= DADOS;
                                        byte_q       <= '0;
                                        byte_atual_q <= prox_dado_d;
                                        mosi_q       <= prox_dado_d[7];
                                        dc_q         <= 1'b1;
                                    end else begin
                                        byte_q       <= byte_q + 11'd1;
                                        byte_atual_q <= prox_cmd_d;
                                        mosi_q       <= prox_cmd_d[7];
                                    end
                                end else
`endif
                                if (byte_q == BYTE_ULT) begin
                                    // Counter parks on the last byte.
                                    estado_q <= GUARDA;
                                    mosi_q   <= 1'b0;
                                end else begin
                                    byte_q       <= byte_q + 11'd1;
                                    byte_atual_q <= prox_dado_d;
                                    mosi_q       <= prox_dado_d[7];
                                end
                            end
                        end
                    end
                end

                // Hold time after the last rising edge before CS is released.
                GUARDA: begin
                    sclk_q <= 1'b0;
                    if (fim_div_d) begin
                        estado_q  <= OCIOSO;
                        div_q     <= '0;
                        byte_q    <= '0;
                        bit_q     <= '0;
                        cs_n_q    <= 1'b1;
                        ocupado_q <= 1'b0;
                        fim_q     <= 1'b1;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end

                default: begin
                    estado_q  <= OCIOSO;
                    cs_n_q    <= 1'b1;
                    sclk_q    <= 1'b0;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign spi_sclk   = sclk_q;
    assign spi_mosi   = mosi_q;
    assign spi_cs_n   = cs_n_q;
    assign spi_dc     = dc_q;
    assign ocupado    = ocupado_q;
    assign quadro_fim = fim_q;

endmodule
